// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the DataPath control strobes.
// Optional CTRL_MEM_WAIT_EN adds mem_ready to stretch the memory-access states.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        ConOut,
  input  logic        stop,
`ifdef CTRL_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
  output logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
  output logic        Gra, Grb, Grc, RIn, ROut, BAOut,
  output logic        Conin,
  output logic        memread, memwrite,
  output logic [4:0]  ALUCode,
  output logic        run,
  output logic        illegal
);

  localparam logic [4:0] ALU_INC = 5'b11111;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR   = 5'b10010, OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT_STOP, S_HALT
  } state_t;

  typedef struct packed {
    logic hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in;
    logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out;
    logic gra, grb, grc, r_in, r_out, ba_out, conin, memread, memwrite;
    logic [4:0] alu;
    logic run, illegal;
  } ctrl_t;

  state_t     state_q, state_d, last_st;
  logic [4:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       known, hold, mem_ok, is_r, is_mem;
  ctrl_t      ctrl_q, ctrl_d;
  logic       unused_ir;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif
  assign unused_ir = ^ir[26:0];

  // Reset parks in S_RESET (treated as T0) so T0's strobes get a full cycle after clear lifts.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      state_q        <= S_RESET;
      op_q           <= 5'd0;
      illegal_q      <= 1'b0;
      ctrl_q         <= '0;
      ctrl_q.run     <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Next state: instruction length and memory holds depend on the latched opcode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    last_st   = S_T3;
    known     = 1'b1;
    hold      = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_st = S_T5;
      OP_LD: begin last_st = S_T7; hold = (state_q == S_T6) && !mem_ok; end
      OP_ST: begin last_st = S_T7; hold = (state_q == S_T7) && !mem_ok; end
      OP_BR: last_st = S_T6;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP: last_st = S_T3;
      default: known = 1'b0;
    endcase
    case (state_q)
      S_RESET:     state_d = S_T0;
      S_T0:        state_d = S_T1;
      S_T1:        if (mem_ok) state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        op_d    = ir[31:27];
      end
      S_HALT_STOP: if (!stop) state_d = S_T0;
      S_HALT:      state_d = S_HALT;
      default: begin
        if (state_q == S_T3 && op_q == OP_HALT) begin
          state_d = S_HALT;
        end else if (state_q == S_T3 && !known) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (hold) begin
          state_d = state_q;
        end else if (state_q == last_st) begin
          state_d = stop ? S_HALT_STOP : S_T0;
        end else begin
          state_d = state_t'(4'(state_q) + 4'd1);
        end
      end
    endcase
  end

  // Strobes for the state being entered, registered at the same negedge.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.run     = 1'b1;
    ctrl_d.illegal = illegal_d;
    is_r   = op_d inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    is_mem = op_d inside {OP_LDI, OP_LD, OP_ST};
    case (state_d)
      S_T0: begin
        ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.z_in = 1'b1; ctrl_d.alu = ALU_INC;
      end
      S_T1: begin
        ctrl_d.zlo_out = 1'b1; ctrl_d.pc_in = 1'b1; ctrl_d.memread = 1'b1; ctrl_d.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1;
      end
      S_HALT_STOP, S_HALT: ctrl_d.run = 1'b0;
      default: begin
        case (op_d)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
            if (state_d == S_T3) begin
              ctrl_d.grb = 1'b1; ctrl_d.y_in = 1'b1;
              if (is_mem) ctrl_d.ba_out = 1'b1;
              else        ctrl_d.r_out  = 1'b1;
            end else if (state_d == S_T4) begin
              ctrl_d.z_in = 1'b1;
              if (is_r) begin
                ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.alu = op_d;
              end else begin
                ctrl_d.c_out = 1'b1;
                ctrl_d.alu   = (op_d == OP_ANDI) ? ALU_AND : (op_d == OP_ORI) ? ALU_OR : ALU_ADD;
              end
            end else if (state_d == S_T5) begin
              ctrl_d.zlo_out = 1'b1;
              if (op_d == OP_LD || op_d == OP_ST) ctrl_d.mar_in = 1'b1;
              else begin ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
            end else if (state_d == S_T6) begin
              ctrl_d.mdr_in = 1'b1;
              if (op_d == OP_LD) ctrl_d.memread = 1'b1;
              else begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; end
            end else if (state_d == S_T7) begin
              if (op_d == OP_LD) begin
                ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1;
              end else ctrl_d.memwrite = 1'b1;
            end
          end
          OP_BR: begin
            if (state_d == S_T3) begin
              ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.conin = 1'b1;
            end else if (state_d == S_T4) begin
              ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1;
            end else if (state_d == S_T5) begin
              ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; ctrl_d.alu = ALU_ADD;
            end else if (state_d == S_T6 && ConOut) begin
              ctrl_d.zlo_out = 1'b1; ctrl_d.pc_in = 1'b1;
            end
          end
          OP_JR:   begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in    = 1'b1; end
          OP_IN:   begin ctrl_d.gra = 1'b1; ctrl_d.r_in  = 1'b1; ctrl_d.iport_out = 1'b1; end
          OP_OUT:  begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.oport_in = 1'b1; end
          OP_MFHI: begin ctrl_d.gra = 1'b1; ctrl_d.r_in  = 1'b1; ctrl_d.hi_out   = 1'b1; end
          OP_MFLO: begin ctrl_d.gra = 1'b1; ctrl_d.r_in  = 1'b1; ctrl_d.lo_out   = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

  assign HiIn = ctrl_q.hi_in;       assign LoIn = ctrl_q.lo_in;     assign ZIn = ctrl_q.z_in;
  assign PCIn = ctrl_q.pc_in;       assign MDRIn = ctrl_q.mdr_in;   assign MARIn = ctrl_q.mar_in;
  assign YIn = ctrl_q.y_in;         assign OPortIn = ctrl_q.oport_in; assign IRIn = ctrl_q.ir_in;
  assign HiOut = ctrl_q.hi_out;     assign LoOut = ctrl_q.lo_out;   assign ZHiOut = ctrl_q.zhi_out;
  assign ZLoOut = ctrl_q.zlo_out;   assign PCOut = ctrl_q.pc_out;   assign MDROut = ctrl_q.mdr_out;
  assign IPortOut = ctrl_q.iport_out; assign COut = ctrl_q.c_out;
  assign Gra = ctrl_q.gra;          assign Grb = ctrl_q.grb;        assign Grc = ctrl_q.grc;
  assign RIn = ctrl_q.r_in;         assign ROut = ctrl_q.r_out;     assign BAOut = ctrl_q.ba_out;
  assign Conin = ctrl_q.conin;      assign memread = ctrl_q.memread; assign memwrite = ctrl_q.memwrite;
  assign ALUCode = ctrl_q.alu;      assign run = ctrl_q.run;        assign illegal = ctrl_q.illegal;

endmodule
